// File: rtl/div32_iter.sv
// Iterative restoring divider for DIV/DIVU.
// One quotient bit per clock; results feed HI/LO.
module div32_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE, CALC, SIGN, DONE
  } state_t;

  state_t state, nxt;

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] r;
  logic [CW-1:0]    cnt;
  logic             qneg;
  logic             rneg;
  logic             dz;

  logic             accept;
  logic             zdiv;
  logic             dsn;
  logic             vsn;
  logic [WIDTH:0]   rs;
  logic [WIDTH:0]   df;

  assign zdiv   = (divisor == '0);
  assign dsn    = is_signed & dividend[WIDTH-1];
  assign vsn    = is_signed & divisor[WIDTH-1];
  assign accept = start & ~cancel &
                  ((state == IDLE) | (state == DONE));
  assign rs     = {r, a[WIDTH-1]};
  assign df     = rs - {1'b0, b};
  assign busy   = (state == CALC) | (state == SIGN);
  assign done   = (state == DONE);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Next-state logic; a zero divisor goes through SIGN
  // so the results latch one edge after start.
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) nxt = zdiv ? SIGN : CALC;
      end
      CALC: begin
        if (cancel)            nxt = IDLE;
        else if (cnt == CW'(1)) nxt = SIGN;
      end
      SIGN: begin
        nxt = cancel ? IDLE : DONE;
      end
      DONE: begin
        if (accept) nxt = zdiv ? SIGN : CALC;
        else        nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // Operand latch and shift-subtract iteration
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a    <= '0;
      b    <= '0;
      r    <= '0;
      cnt  <= '0;
      qneg <= 1'b0;
      rneg <= 1'b0;
      dz   <= 1'b0;
    end else if (accept) begin
      a    <= (dsn & ~zdiv) ? ('0 - dividend)
                            : dividend;
      b    <= vsn ? ('0 - divisor) : divisor;
      r    <= '0;
      cnt  <= CW'(WIDTH);
      qneg <= dsn ^ vsn;
      rneg <= dsn;
      dz   <= zdiv;
    end else if (state == CALC && !cancel) begin
      cnt <= cnt - CW'(1);
      if (!df[WIDTH]) begin
        r <= df[WIDTH-1:0];
        a <= {a[WIDTH-2:0], 1'b1};
      end else begin
        r <= rs[WIDTH-1:0];
        a <= {a[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Result registers, updated only on completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (state == SIGN && !cancel) begin
      if (dz) begin
        quotient    <= '1;
        remainder   <= a;
        div_by_zero <= 1'b1;
      end else begin
        quotient    <= qneg ? ('0 - a) : a;
        remainder   <= rneg ? ('0 - r) : r;
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_div32_iter.sv
// Directed bench for div32_iter.
// Hand-computed DIV/DIVU vectors and handshake timing.
module tb_div32_iter;

  logic        clk;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        cancel;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int errs;
  int checks;

  div32_iter #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .cancel      (cancel),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Issue one divide, wait for done, check
  // latency, results and optionally busy cycles.
  task automatic div_op(input string tag,
                        input logic sg,
                        input logic [31:0] x,
                        input logic [31:0] y,
                        input logic [31:0] eq,
                        input logic [31:0] er,
                        input logic edz,
                        input int elat,
                        input int ebusy);
    int n;
    int nb;
    @(negedge clk);
    start = 1'b1;
    is_signed = sg;
    dividend = x;
    divisor = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    nb = 0;
    while (!done && n < 100) begin
      if (busy) nb++;
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, " lat"}, n, elat);
    chk({tag, " q"}, quotient, eq);
    chk({tag, " r"}, remainder, er);
    chk({tag, " dbz"}, {31'd0, div_by_zero},
        {31'd0, edz});
    if (ebusy >= 0) chk({tag, " busy"}, nb, ebusy);
  endtask

  initial begin
    int nd;
    errs = 0;
    checks = 0;
    rst = 1'b1;
    start = 1'b0;
    is_signed = 1'b0;
    dividend = '0;
    divisor = '0;
    cancel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst q", quotient, 32'd0);
    chk("rst r", remainder, 32'd0);
    chk("rst dbz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    div_op("divu100_7", 1'b0, 32'd100, 32'd7,
           32'd14, 32'd2, 1'b0, 33, 33);
    div_op("div-7_2", 1'b1, 32'hFFFFFFF9, 32'd2,
           32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 33, -1);
    div_op("div7_-2", 1'b1, 32'd7, 32'hFFFFFFFE,
           32'hFFFFFFFD, 32'd1, 1'b0, 33, -1);
    div_op("div-7_-2", 1'b1, 32'hFFFFFFF9,
           32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF,
           1'b0, 33, -1);
    div_op("divu5_0", 1'b0, 32'd5, 32'd0,
           32'hFFFFFFFF, 32'd5, 1'b1, 1, -1);
    div_op("divu9_3", 1'b0, 32'd9, 32'd3,
           32'd3, 32'd0, 1'b0, 33, -1);
    div_op("div-5_0", 1'b1, 32'hFFFFFFFB, 32'd0,
           32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1, 1, -1);
    div_op("div_ovf", 1'b1, 32'h80000000,
           32'hFFFFFFFF, 32'h80000000, 32'd0,
           1'b0, 33, -1);
    div_op("divu_max1", 1'b0, 32'hFFFFFFFF, 32'd1,
           32'hFFFFFFFF, 32'd0, 1'b0, 33, -1);

    // Ignored start while busy, then cancel.
    @(negedge clk);
    start = 1'b1;
    is_signed = 1'b0;
    dividend = 32'd100;
    divisor = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    dividend = 32'd9;
    divisor = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("ign busy", {31'd0, busy}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    cancel = 1'b1;
    @(posedge clk);
    #1;
    cancel = 1'b0;
    chk("cancel busy", {31'd0, busy}, 32'd0);
    nd = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done || busy) nd++;
    end
    chk("cancel nodone", nd, 0);
    chk("cancel q", quotient, 32'hFFFFFFFF);
    chk("cancel r", remainder, 32'd0);

    // Async reset mid-CALC after a zero-divide.
    div_op("pre_rst", 1'b0, 32'd5, 32'd0,
           32'hFFFFFFFF, 32'd5, 1'b1, 1, -1);
    @(negedge clk);
    start = 1'b1;
    dividend = 32'd100;
    divisor = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst busy", {31'd0, busy}, 32'd0);
    chk("arst done", {31'd0, done}, 32'd0);
    chk("arst q", quotient, 32'd0);
    chk("arst r", remainder, 32'd0);
    chk("arst dbz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    div_op("post_rst", 1'b0, 32'd100, 32'd7,
           32'd14, 32'd2, 1'b0, 33, 33);

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule
